// File: rtl/hazard_unit_mc.sv
// -----------------------------------------------------------------------------
// hazard_unit_mc
//
// Hazard and forwarding controller for a 5-stage MIPS pipeline. It sits beside
// the ID/EX stage and decides, every cycle, whether the front of the pipe
// advances, stalls, or is flushed. It also selects the EX operand bypass
// sources.
//
// It handles four things:
//   * a multi-cycle EX unit (MULT/DIV class) that occupies EX for MC_LAT
//     cycles and freezes PC, IF/ID and ID/EX while it runs;
//   * load-use hazards, plus all EX/MEM RAW hazards when forwarding is off;
//   * taken-branch flush of IF/ID and ID/EX;
//   * a saturating count of stall cycles.
//
// Parameters
//   AW      register address width
//   MC_LAT  cycles a multi-cycle op occupies EX (2..255)
//   FWD_EN  1 = forwarding mode, 0 = stall-only mode
//   CNT_W   width of the stall performance counter
//
// Ports
//   i_clock                      pipeline clock, rising edge
//   i_reset_n                    asynchronous active-low reset
//   i_ifid_rs/_rt, i_ifid_uses_rt  sources of the instruction in ID
//   i_idex_rs/_rt/_rd            sources and destination of the EX instruction
//   i_idex_memread/_regwrite/_mc EX instruction: load / writes reg / multi-cycle
//   i_exmem_rd, i_memwb_rd       destinations in MEM and WB
//   i_exmem_regwrite, i_memwb_regwrite  write enables in MEM and WB
//   i_branch_taken               branch resolved taken in EX
//   o_pc_write, o_ifid_write, o_idex_write  stage register enables
//   o_idex_bubble, o_exmem_bubble  load a NOP into ID/EX or EX/MEM
//   o_ifid_flush                 clear IF/ID
//   o_bypass_a, o_bypass_b       00 regfile, 01 MEM/WB, 10 EX/MEM
//   o_mc_busy, o_mc_done         multi-cycle op stalling / completing
//   o_stall_cycles               saturating stall-cycle count
// -----------------------------------------------------------------------------
module hazard_unit_mc #(
    parameter int AW     = 5,
    parameter int MC_LAT = 4,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic [AW-1:0]    i_ifid_rs,
    input  logic [AW-1:0]    i_ifid_rt,
    input  logic             i_ifid_uses_rt,
    input  logic [AW-1:0]    i_idex_rs,
    input  logic [AW-1:0]    i_idex_rt,
    input  logic [AW-1:0]    i_idex_rd,
    input  logic             i_idex_memread,
    input  logic             i_idex_regwrite,
    input  logic             i_idex_mc,
    input  logic [AW-1:0]    i_exmem_rd,
    input  logic [AW-1:0]    i_memwb_rd,
    input  logic             i_exmem_regwrite,
    input  logic             i_memwb_regwrite,
    input  logic             i_branch_taken,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_idex_write,
    output logic             o_idex_bubble,
    output logic             o_exmem_bubble,
    output logic             o_ifid_flush,
    output logic [1:0]       o_bypass_a,
    output logic [1:0]       o_bypass_b,
    output logic             o_mc_busy,
    output logic             o_mc_done,
    output logic [CNT_W-1:0] o_stall_cycles
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // The first stall cycle is spent in IDLE, and the final (done) cycle is
    // spent in BUSY with cnt==0. That leaves MC_LAT-2 countdown steps.
    localparam logic [7:0] MC_LOAD = 8'(MC_LAT - 2);

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_mc_stall;
    logic w_mc_done;
    logic w_load_use;
    logic w_raw_nofwd;
    logic w_data_hazard;
    logic w_data_stall;
    logic w_count_stall;

    // ID instruction reads register rd (register 0 is never a hazard source).
    function automatic logic f_id_reads(
        input logic [AW-1:0] rd,
        input logic [AW-1:0] rs,
        input logic [AW-1:0] rt,
        input logic          uses_rt
    );
        return (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

    // ---------------------------------------------------------------------
    // Multi-cycle sequencer
    // ---------------------------------------------------------------------
    // Gating with i_reset_n releases the stall in the same cycle that reset
    // is asserted, even if the EX stage still shows a multi-cycle op.
    assign w_mc_stall = i_reset_n &&
                        (((r_state == S_IDLE) && i_idex_mc) ||
                         ((r_state == S_BUSY) && (r_cnt != 8'd0)));
    assign w_mc_done  = i_reset_n && (r_state == S_BUSY) && (r_cnt == 8'd0);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_idex_mc) begin
                        r_cnt   <= MC_LOAD;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // idex_mc is not looked at here: on the done cycle the op
                    // is leaving EX, so a following op starts from IDLE.
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Data hazard detection
    // ---------------------------------------------------------------------
    assign w_load_use = i_idex_memread && i_idex_regwrite &&
                        f_id_reads(i_idex_rd, i_ifid_rs, i_ifid_rt, i_ifid_uses_rt);

    generate
        if (FWD_EN != 0) begin : g_fwd_haz
            assign w_raw_nofwd = 1'b0;
        end else begin : g_nofwd_haz
            // No forwarding: the ID instruction must wait until the producer
            // reaches WB. MEM/WB is not checked because the regfile writes in
            // the first half-cycle and reads in the second half.
            assign w_raw_nofwd =
                (i_idex_regwrite &&
                 f_id_reads(i_idex_rd, i_ifid_rs, i_ifid_rt, i_ifid_uses_rt)) ||
                (i_exmem_regwrite &&
                 f_id_reads(i_exmem_rd, i_ifid_rs, i_ifid_rt, i_ifid_uses_rt));
        end
    endgenerate

    assign w_data_hazard = w_load_use || w_raw_nofwd;
    // A taken branch flushes the dependent instruction, so the stall is
    // dropped rather than taken.
    assign w_data_stall  = w_data_hazard && !w_mc_stall && !i_branch_taken;
    assign w_count_stall = w_mc_stall || w_data_stall;

    // ---------------------------------------------------------------------
    // Pipeline control: mc_stall > branch > data stall > normal
    // ---------------------------------------------------------------------
    always_comb begin
        o_pc_write     = 1'b1;
        o_ifid_write   = 1'b1;
        o_idex_write   = 1'b1;
        o_idex_bubble  = 1'b0;
        o_exmem_bubble = 1'b0;
        o_ifid_flush   = 1'b0;
        if (w_mc_stall) begin
            // Hold the op in EX and feed NOPs downstream.
            o_pc_write     = 1'b0;
            o_ifid_write   = 1'b0;
            o_idex_write   = 1'b0;
            o_exmem_bubble = 1'b1;
        end else if (i_branch_taken) begin
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
        end else if (w_data_hazard) begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_idex_bubble = 1'b1;
        end
    end

    assign o_mc_busy = w_mc_stall;
    assign o_mc_done = w_mc_done;

    // ---------------------------------------------------------------------
    // Operand bypass (index 0 = A on idex_rs, 1 = B on idex_rt)
    // ---------------------------------------------------------------------
    logic [AW-1:0] w_ex_src [2];
    logic [1:0]    w_bypass [2];

    assign w_ex_src[0] = i_idex_rs;
    assign w_ex_src[1] = i_idex_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bypass
            if (FWD_EN != 0) begin : g_on
                // EX/MEM holds the younger result, so it wins over MEM/WB.
                always_comb begin
                    w_bypass[gi] = 2'b00;
                    if (i_exmem_regwrite && (i_exmem_rd != '0) &&
                        (i_exmem_rd == w_ex_src[gi])) begin
                        w_bypass[gi] = 2'b10;
                    end else if (i_memwb_regwrite && (i_memwb_rd != '0) &&
                                 (i_memwb_rd == w_ex_src[gi])) begin
                        w_bypass[gi] = 2'b01;
                    end
                end
            end else begin : g_off
                assign w_bypass[gi] = 2'b00;
            end
        end
    endgenerate

    assign o_bypass_a = w_bypass[0];
    assign o_bypass_b = w_bypass[1];

    // ---------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stall_cycles <= '0;
        end else if (w_count_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit_mc
//
// Drives two instances from the same stimulus:
//   dut_f : forwarding mode,  MC_LAT=4, 16-bit counter
//   dut_s : stall-only mode,  MC_LAT=2, 4-bit counter (saturates quickly)
//
// Directed scenarios check fixed expected values. A random phase then compares
// both instances every cycle against a behavioural model. The model tracks a
// multi-cycle op by its position within its EX occupancy, and applies the
// priority rules directly.
// -----------------------------------------------------------------------------
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
    logic       ifid_uses_rt, idex_memread, idex_regwrite, idex_mc;
    logic       exmem_regwrite, memwb_regwrite, branch_taken;

    logic        f_pc_write, f_ifid_write, f_idex_write, f_idex_bubble;
    logic        f_exmem_bubble, f_ifid_flush, f_mc_busy, f_mc_done;
    logic [1:0]  f_bpa, f_bpb;
    logic [15:0] f_stall;
    logic        s_pc_write, s_ifid_write, s_idex_write, s_idex_bubble;
    logic        s_exmem_bubble, s_ifid_flush, s_mc_busy, s_mc_done;
    logic [1:0]  s_bpa, s_bpb;
    logic [3:0]  s_stall;

    logic [11:0] f_vec, s_vec;
    assign f_vec = {f_pc_write, f_ifid_write, f_idex_write, f_idex_bubble, f_exmem_bubble,
                    f_ifid_flush, f_bpa, f_bpb, f_mc_busy, f_mc_done};
    assign s_vec = {s_pc_write, s_ifid_write, s_idex_write, s_idex_bubble, s_exmem_bubble,
                    s_ifid_flush, s_bpa, s_bpb, s_mc_busy, s_mc_done};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.AW(5), .MC_LAT(4), .FWD_EN(1), .CNT_W(16)) dut_f (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_ifid_rs(ifid_rs), .i_ifid_rt(ifid_rt), .i_ifid_uses_rt(ifid_uses_rt),
        .i_idex_rs(idex_rs), .i_idex_rt(idex_rt), .i_idex_rd(idex_rd),
        .i_idex_memread(idex_memread), .i_idex_regwrite(idex_regwrite), .i_idex_mc(idex_mc),
        .i_exmem_rd(exmem_rd), .i_memwb_rd(memwb_rd),
        .i_exmem_regwrite(exmem_regwrite), .i_memwb_regwrite(memwb_regwrite),
        .i_branch_taken(branch_taken),
        .o_pc_write(f_pc_write), .o_ifid_write(f_ifid_write), .o_idex_write(f_idex_write),
        .o_idex_bubble(f_idex_bubble), .o_exmem_bubble(f_exmem_bubble),
        .o_ifid_flush(f_ifid_flush), .o_bypass_a(f_bpa), .o_bypass_b(f_bpb),
        .o_mc_busy(f_mc_busy), .o_mc_done(f_mc_done), .o_stall_cycles(f_stall)
    );

    hazard_unit_mc #(.AW(5), .MC_LAT(2), .FWD_EN(0), .CNT_W(4)) dut_s (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_ifid_rs(ifid_rs), .i_ifid_rt(ifid_rt), .i_ifid_uses_rt(ifid_uses_rt),
        .i_idex_rs(idex_rs), .i_idex_rt(idex_rt), .i_idex_rd(idex_rd),
        .i_idex_memread(idex_memread), .i_idex_regwrite(idex_regwrite), .i_idex_mc(idex_mc),
        .i_exmem_rd(exmem_rd), .i_memwb_rd(memwb_rd),
        .i_exmem_regwrite(exmem_regwrite), .i_memwb_regwrite(memwb_regwrite),
        .i_branch_taken(branch_taken),
        .o_pc_write(s_pc_write), .o_ifid_write(s_ifid_write), .o_idex_write(s_idex_write),
        .o_idex_bubble(s_idex_bubble), .o_exmem_bubble(s_exmem_bubble),
        .o_ifid_flush(s_ifid_flush), .o_bypass_a(s_bpa), .o_bypass_b(s_bpb),
        .o_mc_busy(s_mc_busy), .o_mc_done(s_mc_done), .o_stall_cycles(s_stall)
    );

    // ---------------------------------------------------------------------
    // Reference model (k=0 -> dut_f, k=1 -> dut_s)
    // ---------------------------------------------------------------------
    int m_pos [2];   // cycles the current mc op has already spent in EX (0 = none)
    int m_cnt [2];

    function automatic int f_lat(input int k);  return (k == 0) ? 4 : 2;      endfunction
    function automatic bit f_fwd(input int k);  return (k == 0);              endfunction
    function automatic int f_cmax(input int k); return (k == 0) ? 65535 : 15; endfunction

    // Position (1..LAT) of the mc op within its EX occupancy this cycle, 0 if none.
    function automatic int f_p(input int k);
        if (!rst_n) return 0;
        if (m_pos[k] != 0) return m_pos[k] + 1;
        return idex_mc ? 1 : 0;
    endfunction

    function automatic bit f_mcst(input int k);
        int p;
        p = f_p(k);
        return (p != 0) && (p < f_lat(k));
    endfunction

    function automatic bit f_reads(input logic [4:0] rd);
        return (rd != 5'd0) && ((rd == ifid_rs) || (ifid_uses_rt && (rd == ifid_rt)));
    endfunction

    function automatic bit f_haz(input int k);
        bit lu;
        lu = idex_memread && idex_regwrite && f_reads(idex_rd);
        if (f_fwd(k)) return lu;
        return lu || (idex_regwrite && f_reads(idex_rd)) || (exmem_regwrite && f_reads(exmem_rd));
    endfunction

    function automatic logic [1:0] f_byp(input int k, input logic [4:0] src);
        if (!f_fwd(k)) return 2'b00;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == src)) return 2'b10;
        if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == src)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [11:0] f_expect(input int k);
        logic [5:0] ctl;
        bit         dn;
        dn = (f_p(k) == f_lat(k));
        if (f_mcst(k))         ctl = 6'b000_010;
        else if (branch_taken) ctl = 6'b111_101;
        else if (f_haz(k))     ctl = 6'b001_100;
        else                   ctl = 6'b111_000;
        return {ctl, f_byp(k, idex_rs), f_byp(k, idex_rt), f_mcst(k), dn};
    endfunction

    function automatic bit f_inc(input int k);
        return f_mcst(k) || (!branch_taken && f_haz(k));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_pos[k] <= 0;
                m_cnt[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_pos[k] <= f_mcst(k) ? f_p(k) : 0;
                if (f_inc(k) && (m_cnt[k] < f_cmax(k))) m_cnt[k] <= m_cnt[k] + 1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ---------------------------------------------------------------------
    task automatic clear_inputs();
        ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 0;
        idex_rs = 0; idex_rt = 0; idex_rd = 0;
        idex_memread = 0; idex_regwrite = 0; idex_mc = 0;
        exmem_rd = 0; memwb_rd = 0; exmem_regwrite = 0; memwb_regwrite = 0;
        branch_taken = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        clear_inputs();
        #2 rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (f_vec !== 12'b111000000000) $display("FAIL reset_f_ctl: got %b expected %b", f_vec, 12'b111000000000);
        else n_pass++;
        n_checks++;
        if (s_vec !== 12'b111000000000) $display("FAIL reset_s_ctl: got %b expected %b", s_vec, 12'b111000000000);
        else n_pass++;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (f_stall !== 16'd0 || s_stall !== 4'd0)
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", f_stall, s_stall);
        else n_pass++;
        n_checks++;
        if (f_vec !== 12'b111000000000) $display("FAIL reset_rel_ctl: got %b expected %b", f_vec, 12'b111000000000);
        else n_pass++;
        $display("reset: f_vec=%b s_vec=%b", f_vec, s_vec);
    endtask

    task automatic test_mc_single();
        logic [15:0] c0;
        next_cycle();
        c0 = f_stall;
        idex_mc = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (f_mc_busy !== (cyc < 3) || f_mc_done !== (cyc == 3) ||
                f_exmem_bubble !== (cyc < 3) || f_pc_write !== (cyc == 3))
                $display("FAIL mc_single_c%0d: got busy=%b done=%b exb=%b pc=%b expected %b %b %b %b",
                         cyc, f_mc_busy, f_mc_done, f_exmem_bubble, f_pc_write,
                         cyc < 3, cyc == 3, cyc < 3, cyc == 3);
            else n_pass++;
            n_checks++;
            if (s_vec !== f_expect(1)) $display("FAIL mc_single_s_c%0d: got %b expected %b", cyc, s_vec, f_expect(1));
            else n_pass++;
            $display("mc_single cycle %0d: busy=%b done=%b", cyc, f_mc_busy, f_mc_done);
            next_cycle();
        end
        idex_mc = 1'b0;
        @(negedge clk);
        n_checks++;
        if (f_stall - c0 !== 16'd3 || f_mc_busy !== 1'b0)
            $display("FAIL mc_single_cnt: got delta=%0d busy=%b expected 3 0", f_stall - c0, f_mc_busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit exp_busy [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
        bit exp_done [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        next_cycle();
        idex_mc = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc == 5) idex_mc = 1'b0;
            @(negedge clk);
            n_checks++;
            if (f_mc_busy !== exp_busy[cyc] || f_mc_done !== exp_done[cyc])
                $display("FAIL b2b_c%0d: got busy=%b done=%b expected %b %b",
                         cyc, f_mc_busy, f_mc_done, exp_busy[cyc], exp_done[cyc]);
            else n_pass++;
            $display("b2b cycle %0d: busy=%b done=%b", cyc, f_mc_busy, f_mc_done);
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_op();
        idex_mc = 1'b1;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (f_mc_busy !== 1'b1) $display("FAIL midrst_pre: got busy=%b expected 1", f_mc_busy);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (f_mc_busy !== 1'b0 || f_pc_write !== 1'b1 || s_mc_busy !== 1'b0 || f_stall !== 16'd0)
            $display("FAIL midrst_asserted: got busy=%b pc=%b sbusy=%b cnt=%0d expected 0 1 0 0",
                     f_mc_busy, f_pc_write, s_mc_busy, f_stall);
        else n_pass++;
        idex_mc = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (f_pc_write !== 1'b1 || f_mc_busy !== 1'b0 || f_stall !== 16'd0 || s_stall !== 4'd0)
            $display("FAIL midrst_release: got pc=%b busy=%b cnt=%0d/%0d expected 1 0 0/0",
                     f_pc_write, f_mc_busy, f_stall, s_stall);
        else n_pass++;
        $display("reset mid-op: pc=%b busy=%b cnt=%0d", f_pc_write, f_mc_busy, f_stall);
    endtask

    task automatic test_bypass();
        next_cycle();
        clear_inputs();
        idex_rs = 5; exmem_rd = 5; memwb_rd = 5; exmem_regwrite = 1; memwb_regwrite = 1;
        @(negedge clk);
        n_checks++;
        if (f_bpa !== 2'b10 || s_bpa !== 2'b00) $display("FAIL byp_exmem: got %b/%b expected 10/00", f_bpa, s_bpa);
        else n_pass++;
        exmem_regwrite = 0;
        #1;
        n_checks++;
        if (f_bpa !== 2'b01) $display("FAIL byp_memwb: got %b expected 01", f_bpa);
        else n_pass++;
        exmem_rd = 0; memwb_rd = 0; exmem_regwrite = 1; idex_rs = 0;
        #1;
        n_checks++;
        if (f_bpa !== 2'b00) $display("FAIL byp_r0: got %b expected 00", f_bpa);
        else n_pass++;
        idex_rs = 5; idex_rt = 7; exmem_rd = 7; memwb_rd = 5;
        #1;
        n_checks++;
        if (f_bpa !== 2'b01 || f_bpb !== 2'b10) $display("FAIL byp_ab: got %b %b expected 01 10", f_bpa, f_bpb);
        else n_pass++;
        next_cycle();
        idex_mc = 1'b1;
        @(negedge clk);
        n_checks++;
        if (f_mc_busy !== 1'b1 || f_bpb !== 2'b10) $display("FAIL byp_mc: got busy=%b b=%b expected 1 10", f_mc_busy, f_bpb);
        else n_pass++;
        $display("bypass: a=%b b=%b", f_bpa, f_bpb);
        next_cycle();
        idex_mc = 1'b0;
        repeat (3) next_cycle();
        clear_inputs();
    endtask

    task automatic test_load_use();
        logic [15:0] c0;
        next_cycle();
        clear_inputs();
        c0 = f_stall;
        idex_memread = 1; idex_regwrite = 1; idex_rd = 8; ifid_rs = 1; ifid_rt = 8; ifid_uses_rt = 1;
        @(negedge clk);
        n_checks++;
        if (f_pc_write !== 1'b0 || f_ifid_write !== 1'b0 || f_idex_bubble !== 1'b1 || f_idex_write !== 1'b1)
            $display("FAIL loaduse_stall: got pc=%b ifid=%b bub=%b idex=%b expected 0 0 1 1",
                     f_pc_write, f_ifid_write, f_idex_bubble, f_idex_write);
        else n_pass++;
        next_cycle();
        ifid_uses_rt = 0;
        @(negedge clk);
        n_checks++;
        if (f_pc_write !== 1'b1 || f_idex_bubble !== 1'b0 || f_stall - c0 !== 16'd1)
            $display("FAIL loaduse_no_rt: got pc=%b bub=%b delta=%0d expected 1 0 1",
                     f_pc_write, f_idex_bubble, f_stall - c0);
        else n_pass++;
        n_checks++;
        if (s_vec !== f_expect(1)) $display("FAIL loaduse_s: got %b expected %b", s_vec, f_expect(1));
        else n_pass++;
        $display("load-use: pc=%b bub=%b", f_pc_write, f_idex_bubble);
    endtask

    task automatic test_nofwd_stall();
        next_cycle();
        clear_inputs();
        exmem_rd = 3; exmem_regwrite = 1; ifid_rs = 3; idex_rs = 3;
        @(negedge clk);
        n_checks++;
        if (s_pc_write !== 1'b0 || s_idex_bubble !== 1'b1 || s_bpa !== 2'b00 || s_bpb !== 2'b00)
            $display("FAIL nofwd_stall: got pc=%b bub=%b a=%b b=%b expected 0 1 00 00",
                     s_pc_write, s_idex_bubble, s_bpa, s_bpb);
        else n_pass++;
        n_checks++;
        if (f_pc_write !== 1'b1 || f_bpa !== 2'b10) $display("FAIL nofwd_fwdmode: got pc=%b a=%b expected 1 10", f_pc_write, f_bpa);
        else n_pass++;
        $display("no-forward stall: s_pc=%b f_pc=%b", s_pc_write, f_pc_write);
    endtask

    task automatic test_branch_override();
        logic [15:0] c0;
        next_cycle();
        clear_inputs();
        c0 = f_stall;
        idex_memread = 1; idex_regwrite = 1; idex_rd = 9; ifid_rs = 9; branch_taken = 1;
        @(negedge clk);
        n_checks++;
        if (f_ifid_flush !== 1'b1 || f_pc_write !== 1'b1 || f_idex_bubble !== 1'b1 || f_ifid_write !== 1'b1)
            $display("FAIL branch_ovr: got flush=%b pc=%b bub=%b ifid=%b expected 1 1 1 1",
                     f_ifid_flush, f_pc_write, f_idex_bubble, f_ifid_write);
        else n_pass++;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (f_stall !== c0) $display("FAIL branch_cnt: got %0d expected %0d", f_stall, c0);
        else n_pass++;
        $display("branch override: flush=%b cnt=%0d", f_ifid_flush, f_stall);
    endtask

    task automatic test_random();
        int nerr;
        nerr = 0;
        for (int i = 0; i < 600; i++) begin
            next_cycle();
            ifid_rs = 5'($urandom_range(0, 7)); ifid_rt = 5'($urandom_range(0, 7));
            idex_rs = 5'($urandom_range(0, 7)); idex_rt = 5'($urandom_range(0, 7));
            idex_rd = 5'($urandom_range(0, 7)); exmem_rd = 5'($urandom_range(0, 7));
            memwb_rd = 5'($urandom_range(0, 7));
            ifid_uses_rt = 1'($urandom_range(0, 1)); idex_memread = 1'($urandom_range(0, 1));
            idex_regwrite = 1'($urandom_range(0, 1)); exmem_regwrite = 1'($urandom_range(0, 1));
            memwb_regwrite = 1'($urandom_range(0, 1));
            idex_mc = ($urandom_range(0, 7) == 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            n_checks++;
            if (f_vec !== f_expect(0) || f_stall !== 16'(m_cnt[0])) begin
                $display("FAIL rand_f_%0d: got %b cnt=%0d expected %b cnt=%0d", i, f_vec, f_stall, f_expect(0), m_cnt[0]);
                nerr++;
            end else n_pass++;
            n_checks++;
            if (s_vec !== f_expect(1) || s_stall !== 4'(m_cnt[1])) begin
                $display("FAIL rand_s_%0d: got %b cnt=%0d expected %b cnt=%0d", i, s_vec, s_stall, f_expect(1), m_cnt[1]);
                nerr++;
            end else n_pass++;
        end
        $display("random: 600 cycles, %0d errors, f_cnt=%0d s_cnt=%0d", nerr, f_stall, s_stall);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_mc_single();
        test_back_to_back();
        test_reset_mid_op();
        test_bypass();
        test_load_use();
        test_nofwd_stall();
        test_branch_override();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
